// File: rtl/fx_pkg.sv
// Shared types and defaults for the effect frame sequencer.
// The CLIP_COUNT_EN build option (see fx_frame_sequencer) uses the clip constants below.
package fx_pkg;

   localparam int DEF_FRAME_LEN  = 1000;
   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_FX_TIMEOUT = 15;

   localparam logic [DEF_DATA_W-1:0] SAMPLE_MAX = 16'h7FFF;
   localparam logic [DEF_DATA_W-1:0] SAMPLE_MIN = 16'h8000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      FX_GO   = 3'd3,
      FX_WAIT = 3'd4,
      WRITE   = 3'd5,
      DONE_ST = 3'd6
   } state_t;

   // A sample sitting on either rail is taken as clipped.
   function automatic logic is_clip(input logic [DEF_DATA_W-1:0] s);
      return (s == SAMPLE_MAX) || (s == SAMPLE_MIN);
   endfunction

endpackage

// File: rtl/fx_timeout_counter.sv
// Counts cycles spent waiting on the effect; flags expiry on the cycle the count reaches LIMIT.
module fx_timeout_counter #(
   parameter int LIMIT = 15,
   parameter int CNT_W = $clog2(LIMIT + 1)
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_r;

   // Wait-cycle counter, saturating one short of LIMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable && (count_r != LAST)) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/fx_frame_sequencer.sv
// Streams one frame from the input RAM through a START/DONE effect unit into the output RAM.
// Build option CLIP_COUNT_EN adds the clip_count output.
module fx_frame_sequencer
   import fx_pkg::*;
#(
   parameter int FRAME_LEN  = DEF_FRAME_LEN,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FX_TIMEOUT = DEF_FX_TIMEOUT
)(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FRAME_START,
   input  logic              BYPASS,
   input  logic              GAIN_CFG,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic              ERROR,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              fx_start,
   output logic              fx_gain,
   output logic [DATA_W-1:0] fx_in,
   input  logic              fx_done,
   input  logic [DATA_W-1:0] fx_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
`ifdef CLIP_COUNT_EN
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] clip_count
`else
   output logic [DATA_W-1:0] wr_data
`endif
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   state_t            state_r;
   state_t            next_s;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] idx_next_s;
   logic              bypass_r;
   logic              gain_r;
   logic [DATA_W-1:0] sample_r;
   logic [DATA_W-1:0] result_r;
   logic              accept_s;
   logic              abort_s;
   logic              expired_s;
   logic              to_clear_s;
   logic              to_enable_s;

   assign fx_in   = sample_r;
   assign wr_data = result_r;
   assign fx_gain = gain_r;

   assign to_clear_s  = (state_r == FX_GO);
   assign to_enable_s = (state_r == FX_WAIT) && !fx_done;

   fx_timeout_counter #(
      .LIMIT (FX_TIMEOUT)
   ) u_timeout (
      .clk     (CLK),
      .reset   (RESET),
      .clear   (to_clear_s),
      .enable  (to_enable_s),
      .expired (expired_s)
   );

   // Next-state, sample index and frame accept/abort decode.
   always_comb begin
      next_s     = state_r;
      idx_next_s = idx_r;
      accept_s   = 1'b0;
      abort_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (FRAME_START) begin
               next_s     = READ;
               idx_next_s = {ADDR_W{1'b0}};
               accept_s   = 1'b1;
            end else begin
               next_s = IDLE;
            end
         end
         READ:    next_s = CAPTURE;
         CAPTURE: begin
            if (bypass_r) begin
               next_s = WRITE;
            end else begin
               next_s = FX_GO;
            end
         end
         FX_GO:   next_s = FX_WAIT;
         FX_WAIT: begin
            if (fx_done) begin
               next_s = WRITE;
            end else if (expired_s) begin
               next_s  = IDLE;
               abort_s = 1'b1;
            end else begin
               next_s = FX_WAIT;
            end
         end
         WRITE: begin
            if (idx_r == LAST_IDX) begin
               next_s = DONE_ST;
            end else begin
               next_s     = READ;
               idx_next_s = idx_r + ADDR_W'(1);
            end
         end
         DONE_ST: next_s = IDLE;
         default: begin
            next_s     = IDLE;
            idx_next_s = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State, datapath registers and outputs; strobes are decoded from the next state so they align with it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r    <= IDLE;
         idx_r      <= {ADDR_W{1'b0}};
         bypass_r   <= 1'b0;
         gain_r     <= 1'b0;
         sample_r   <= {DATA_W{1'b0}};
         result_r   <= {DATA_W{1'b0}};
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
         ERROR      <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= {ADDR_W{1'b0}};
         fx_start   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= {ADDR_W{1'b0}};
      end else begin
         state_r    <= next_s;
         idx_r      <= idx_next_s;
         BUSY       <= next_s inside {READ, CAPTURE, FX_GO, FX_WAIT, WRITE};
         FRAME_DONE <= (next_s == DONE_ST) || abort_s;
         rd_en      <= (next_s == READ);
         rd_addr    <= idx_next_s;
         fx_start   <= (next_s == FX_GO);
         wr_en      <= (next_s == WRITE);
         wr_addr    <= idx_next_s;
         if (accept_s) begin
            bypass_r <= BYPASS;
            gain_r   <= GAIN_CFG;
            ERROR    <= 1'b0;
         end else if (abort_s) begin
            ERROR <= 1'b1;
         end
         // In bypass the result register doubles as the write-back copy of the sample.
         if (state_r == CAPTURE) begin
            sample_r <= rd_data;
            if (bypass_r) begin
               result_r <= rd_data;
            end
         end else if ((state_r == FX_WAIT) && fx_done) begin
            result_r <= fx_out;
         end
      end
   end

`ifdef CLIP_COUNT_EN
   // Clipped-sample tally for the current frame, held after the frame ends.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         clip_count <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         clip_count <= {ADDR_W{1'b0}};
      end else if ((state_r == WRITE) && is_clip(result_r)) begin
         clip_count <= clip_count + ADDR_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fx_frame_sequencer.sv
// Self-checking bench: RAM and overdrive models driven cycle by cycle, results checked
// against frame-level expectations. Define CLIP_COUNT_EN to also check clip_count.
module tb_fx_frame_sequencer;

   localparam int FL = 4;
   localparam int AW = 10;
   localparam int DW = 16;
   localparam int TO = 15;

   logic          CLK = 1'b0;
   logic          RESET, FRAME_START, BYPASS, GAIN_CFG;
   logic          BUSY, FRAME_DONE, ERROR, rd_en, fx_start, fx_gain, fx_done, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] rd_data, fx_in, fx_out, wr_data;
`ifdef CLIP_COUNT_EN
   logic [AW-1:0] clip_count;
`endif

   always #5 CLK = ~CLK;

   fx_frame_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW), .DATA_W(DW), .FX_TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .BYPASS(BYPASS), .GAIN_CFG(GAIN_CFG),
      .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .ERROR(ERROR),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .fx_start(fx_start), .fx_gain(fx_gain), .fx_in(fx_in), .fx_done(fx_done), .fx_out(fx_out),
      .wr_en(wr_en), .wr_addr(wr_addr),
`ifdef CLIP_COUNT_EN
      .wr_data(wr_data), .clip_count(clip_count)
`else
      .wr_data(wr_data)
`endif
   );

   logic [DW-1:0] ram_in  [FL];
   logic [DW-1:0] out_mem [FL];
   logic [DW-1:0] exp_mem [FL];
   int            wr_log[$];
   int            checks = 0, errors = 0;
   int            cyc = 0, done_count, busy_cycles, fx_start_count, done_cyc, last_fx_start_cyc;
   int            cur_idx = 0, hang_idx = -1;
   bit            noise_en = 1'b0;
   logic          err_at_done;

   // Overdrive reference: gain x2 (cfg 0) or x4 (cfg 1), saturated to the signed range.
   function automatic logic [DW-1:0] od(input logic [DW-1:0] x, input logic g);
      int v;
      v = int'($signed(x)) * (g ? 4 : 2);
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      return 16'(v);
   endfunction

   task automatic tick();
      logic          p_rd_en, p_fx_start, p_gain;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_fx_in;
      p_rd_en = rd_en; p_addr = rd_addr; p_fx_start = fx_start; p_gain = fx_gain; p_fx_in = fx_in;
      @(posedge CLK); #1;
      cyc++;
      if (p_rd_en === 1'b1) begin
         rd_data = ram_in[p_addr];
         cur_idx = int'(p_addr);
      end
      if (p_fx_start === 1'b1 && cur_idx != hang_idx) begin
         fx_done = 1'b1;
         fx_out  = od(p_fx_in, p_gain);
      end else if (noise_en) begin
         fx_done = 1'($urandom_range(0, 1));
         fx_out  = 16'($urandom);
      end else begin
         fx_done = 1'b0;
         fx_out  = 16'h0000;
      end
      if (wr_en === 1'b1) begin
         if (int'(wr_addr) < FL) out_mem[wr_addr] = wr_data;
         wr_log.push_back(int'(wr_addr));
      end
      if (FRAME_DONE === 1'b1) begin
         done_count++;
         done_cyc    = cyc;
         err_at_done = ERROR;
      end
      if (BUSY === 1'b1) busy_cycles++;
      if (fx_start === 1'b1) begin
         fx_start_count++;
         last_fx_start_cyc = cyc;
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      for (int i = 0; i < FL; i++) out_mem[i] = 'x;
      done_count = 0; busy_cycles = 0; fx_start_count = 0; done_cyc = -1; last_fx_start_cyc = -1;
   endtask

   // Pulse FRAME_START, then flip the mode inputs to show they were latched.
   task automatic start_frame(input logic b, input logic g);
      clear_logs();
      BYPASS = b; GAIN_CFG = g; FRAME_START = 1'b1;
      tick();
      FRAME_START = 1'b0; BYPASS = ~b; GAIN_CFG = ~g;
   endtask

   task automatic wait_done();
      for (int i = 0; i < FL * 5 + 60 && done_count == 0; i++) tick();
      checks++;
      if (done_count == 0) begin
         errors++;
         $display("FAIL frame_done_wait got no FRAME_DONE within budget");
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      RESET = 1'b1; FRAME_START = 1'b0; BYPASS = 1'b0; GAIN_CFG = 1'b0;
      rd_data = '0; fx_done = 1'b0; fx_out = '0;
      tick(); tick();
      checks++;
      if ({BUSY, FRAME_DONE, ERROR, rd_en, rd_addr, fx_start, fx_gain, fx_in, wr_en, wr_addr, wr_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b rd_en=%b wr_en=%b fx_start=%b required all 0",
                  BUSY, FRAME_DONE, ERROR, rd_en, wr_en, fx_start);
      end
`ifdef CLIP_COUNT_EN
      checks++;
      if (clip_count !== '0) begin errors++; $display("FAIL reset_clip got %0d required 0", clip_count); end
`endif
      RESET = 1'b0;
      tick();
   endtask

   task automatic test_effect_frame();
      ram_in[0] = 16'd100; ram_in[1] = -16'sd200; ram_in[2] = 16'h4000; ram_in[3] = -16'sh5000;
      exp_mem[0] = 16'd200; exp_mem[1] = -16'sd400; exp_mem[2] = 16'h7FFF; exp_mem[3] = 16'h8000;
      start_frame(1'b0, 1'b0);
      wait_done();
      for (int i = 0; i < FL; i++) begin
         checks++;
         if (out_mem[i] !== exp_mem[i]) begin errors++; $display("FAIL fx_data[%0d] got %h required %h", i, out_mem[i], exp_mem[i]); end
      end
      checks++;
      if (wr_log.size() != FL) begin errors++; $display("FAIL fx_wr_count got %0d required %0d", wr_log.size(), FL); end
      for (int i = 0; i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] != i) begin errors++; $display("FAIL fx_wr_addr[%0d] got %0d required %0d", i, wr_log[i], i); end
      end
      checks++;
      if (done_count != 1) begin errors++; $display("FAIL fx_done_pulses got %0d required 1", done_count); end
      checks++;
      if (busy_cycles != FL * 5) begin errors++; $display("FAIL fx_cycles got %0d required %0d", busy_cycles, FL * 5); end
      checks++;
      if (fx_start_count != FL) begin errors++; $display("FAIL fx_start_count got %0d required %0d", fx_start_count, FL); end
      checks++;
      if (ERROR !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL fx_end_flags got err=%b busy=%b required 0 0", ERROR, BUSY); end
`ifdef CLIP_COUNT_EN
      checks++;
      if (clip_count !== 10'd2) begin errors++; $display("FAIL clip_count got %0d required 2", clip_count); end
`endif
   endtask

   task automatic test_bypass();
      noise_en = 1'b1;
      start_frame(1'b1, 1'b1);
      wait_done();
      noise_en = 1'b0;
      for (int i = 0; i < FL; i++) begin
         checks++;
         if (out_mem[i] !== ram_in[i]) begin errors++; $display("FAIL byp_data[%0d] got %h required %h", i, out_mem[i], ram_in[i]); end
      end
      checks++;
      if (fx_start_count != 0) begin errors++; $display("FAIL byp_fx_start got %0d required 0", fx_start_count); end
      checks++;
      if (busy_cycles != FL * 3) begin errors++; $display("FAIL byp_cycles got %0d required %0d", busy_cycles, FL * 3); end
      checks++;
      if (done_count != 1 || wr_log.size() != FL) begin
         errors++; $display("FAIL byp_counts got done=%0d writes=%0d required 1 %0d", done_count, wr_log.size(), FL);
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 6; f++) begin
         logic b, g;
         int   exp_clip;
         b = 1'($urandom_range(0, 1)); g = 1'($urandom_range(0, 1));
         exp_clip = 0;
         for (int i = 0; i < FL; i++) begin
            ram_in[i]  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
            exp_mem[i] = b ? ram_in[i] : od(ram_in[i], g);
            if (exp_mem[i] == 16'h7FFF || exp_mem[i] == 16'h8000) exp_clip++;
         end
         noise_en = b;
         start_frame(b, g);
         wait_done();
         noise_en = 1'b0;
         for (int i = 0; i < FL; i++) begin
            checks++;
            if (out_mem[i] !== exp_mem[i]) begin
               errors++; $display("FAIL rnd%0d_data[%0d] byp=%b gain=%b got %h required %h", f, i, b, g, out_mem[i], exp_mem[i]);
            end
         end
         checks++;
         if (busy_cycles != FL * (b ? 3 : 5) || done_count != 1) begin
            errors++; $display("FAIL rnd%0d_timing got busy=%0d done=%0d required %0d 1", f, busy_cycles, done_count, FL * (b ? 3 : 5));
         end
`ifdef CLIP_COUNT_EN
         checks++;
         if (int'(clip_count) != exp_clip) begin errors++; $display("FAIL rnd%0d_clip got %0d required %0d", f, clip_count, exp_clip); end
`endif
      end
   endtask

   task automatic test_timeout();
      hang_idx = 2;
      start_frame(1'b0, 1'($urandom_range(0, 1)));
      wait_done();
      checks++;
      if (err_at_done !== 1'b1 || ERROR !== 1'b1) begin
         errors++; $display("FAIL to_error got at_done=%b now=%b required 1 1", err_at_done, ERROR);
      end
      checks++;
      if (done_cyc - last_fx_start_cyc != TO + 1) begin
         errors++; $display("FAIL to_wait_cycles got %0d required %0d", done_cyc - last_fx_start_cyc - 1, TO);
      end
      checks++;
      if (wr_log.size() != 2 || done_count != 1 || BUSY !== 1'b0) begin
         errors++; $display("FAIL to_writes got writes=%0d done=%0d busy=%b required 2 1 0", wr_log.size(), done_count, BUSY);
      end
      for (int i = 0; i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] != i) begin errors++; $display("FAIL to_wr_addr[%0d] got %0d required %0d", i, wr_log[i], i); end
      end
      hang_idx = -1;
      start_frame(1'b0, 1'b0);
      checks++;
      if (ERROR !== 1'b0) begin errors++; $display("FAIL to_error_clear got %b required 0", ERROR); end
      wait_done();
      checks++;
      if (done_count != 1 || wr_log.size() != FL || ERROR !== 1'b0) begin
         errors++; $display("FAIL to_recover got done=%0d writes=%0d err=%b required 1 %0d 0", done_count, wr_log.size(), ERROR, FL);
      end
   endtask

   task automatic test_restart_ignored();
      for (int i = 0; i < FL; i++) begin
         ram_in[i]  = 16'($urandom_range(0, 6000) - 3000);
         exp_mem[i] = od(ram_in[i], 1'b0);
      end
      start_frame(1'b0, 1'b0);
      repeat (6) tick();
      FRAME_START = 1'b1; GAIN_CFG = 1'b1; BYPASS = 1'b1;
      tick();
      FRAME_START = 1'b0;
      checks++;
      if (fx_gain !== 1'b0) begin errors++; $display("FAIL rst_gain got %b required 0", fx_gain); end
      wait_done();
      for (int i = 0; i < FL; i++) begin
         checks++;
         if (out_mem[i] !== exp_mem[i]) begin errors++; $display("FAIL restart_data[%0d] got %h required %h", i, out_mem[i], exp_mem[i]); end
      end
      checks++;
      if (done_count != 1 || wr_log.size() != FL || busy_cycles != FL * 5) begin
         errors++; $display("FAIL restart_counts got done=%0d writes=%0d busy=%0d required 1 %0d %0d",
                            done_count, wr_log.size(), busy_cycles, FL, FL * 5);
      end
      for (int i = 0; i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] != i) begin errors++; $display("FAIL restart_wr_addr[%0d] got %0d required %0d", i, wr_log[i], i); end
      end
   endtask

   task automatic test_reset_midframe();
      bit seen;
      seen = 1'b0;
      start_frame(1'b0, 1'b1);
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (rd_en === 1'b1 && rd_addr == 10'd1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL midreset_reach got no read of address 1"); end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      checks++;
      if ({BUSY, FRAME_DONE, ERROR, rd_en, rd_addr, fx_start, fx_gain, fx_in, wr_en, wr_addr, wr_data} !== '0) begin
         errors++; $display("FAIL midreset_outputs got busy=%b rd_en=%b fx_gain=%b wr_en=%b fx_in=%h required all 0",
                            BUSY, rd_en, fx_gain, wr_en, fx_in);
      end
      clear_logs();
      repeat (30) tick();
      checks++;
      if (done_count != 0 || wr_log.size() != 0 || BUSY !== 1'b0) begin
         errors++; $display("FAIL midreset_quiet got done=%0d writes=%0d busy=%b required 0 0 0", done_count, wr_log.size(), BUSY);
      end
      for (int i = 0; i < FL; i++) exp_mem[i] = od(ram_in[i], 1'b1);
      start_frame(1'b0, 1'b1);
      wait_done();
      for (int i = 0; i < FL; i++) begin
         checks++;
         if (out_mem[i] !== exp_mem[i]) begin errors++; $display("FAIL postreset_data[%0d] got %h required %h", i, out_mem[i], exp_mem[i]); end
      end
      checks++;
      if (wr_log.size() != FL || wr_log[0] != 0 || done_count != 1) begin
         errors++; $display("FAIL postreset_counts got writes=%0d done=%0d required %0d 1", wr_log.size(), done_count, FL);
      end
   endtask

   initial begin
      test_reset();
      test_effect_frame();
      test_bypass();
      test_random_frames();
      test_timeout();
      test_restart_ignored();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fx_frame_sequencer.md
Name: fx_frame_sequencer

Overview:
- Sequences one audio frame through a single-sample effect unit, such as the overdrive stage, which uses a START/DONE handshake.
- Per sample: reads from the input frame RAM, hands the sample to the effect, waits for DONE, and writes the result to the output frame RAM.
- Sits between the frame buffers and the effect datapath; the top-level pedal controller triggers it once per frame.

Parameters:
FRAME_LEN, 1000, samples per frame
ADDR_W, 10, RAM address width; must satisfy 2**ADDR_W >= FRAME_LEN
DATA_W, 16, signed sample width
FX_TIMEOUT, 15, max cycles spent waiting for fx_done before aborting the frame

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
FRAME_START  in  1  one-cycle pulse; begin a frame (ignored while BUSY)
BYPASS  in  1  when 1, samples are copied without using the effect; sampled at frame start
GAIN_CFG  in  1  effect gain select; sampled at frame start
BUSY  out  1  high from the cycle after an accepted FRAME_START until FRAME_DONE
FRAME_DONE  out  1  one-cycle pulse when the frame completes or aborts
ERROR  out  1  sticky effect-timeout flag; cleared by RESET or an accepted FRAME_START
rd_en  out  1  input RAM read strobe
rd_addr  out  ADDR_W  input RAM address
rd_data  in  DATA_W  input RAM data, valid 1 cycle after rd_en
fx_start  out  1  effect START
fx_gain  out  1  latched gain to the effect
fx_in  out  DATA_W  sample to the effect, held stable from fx_start until fx_done
fx_done  in  1  effect DONE pulse
fx_out  in  DATA_W  effect result, valid with fx_done
wr_en  out  1  output RAM write strobe
wr_addr  out  ADDR_W  output RAM address
wr_data  out  DATA_W  output RAM data

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE. RESET mid-frame aborts immediately, with no FRAME_DONE pulse and no further writes.
- IDLE:
  - An accepted FRAME_START latches BYPASS and GAIN_CFG, sets idx=0, clears ERROR and goes to READ.
  - A FRAME_START that arrives while not in IDLE is dropped.
- READ: rd_en=1 with rd_addr=idx; go to CAPTURE.
- CAPTURE:
  - Register rd_data into the sample register, which drives fx_in.
  - If bypass is set, go to WRITE; otherwise go to FX_GO.
- FX_GO: fx_start=1 for exactly one cycle; clear the timeout counter; go to FX_WAIT.
- FX_WAIT:
  - fx_done=1 captures fx_out into the result register and goes to WRITE.
  - Otherwise the counter increments. When it reaches FX_TIMEOUT, set ERROR, pulse FRAME_DONE and go to IDLE; the current sample is not written.
- WRITE:
  - wr_en=1 with wr_addr=idx; wr_data is the result register, or the sample register in bypass.
  - If idx==FRAME_LEN-1, go to DONE_ST; otherwise idx+1 and go to READ.
- DONE_ST: FRAME_DONE=1 for one cycle, BUSY drops in the same cycle, go to IDLE.
- Throughput:
  - Effect path: 4 cycles per sample plus the fx_done latency, which is 1 cycle for the overdrive stage, giving 5 cycles/sample.
  - Bypass: 3 cycles per sample.
- fx_done outside FX_WAIT is ignored.
- idx never exceeds FRAME_LEN-1; there is no wrap-around.
- fx_gain holds its latched value for the whole frame.
- All outputs are registered, except fx_in, wr_data and fx_gain, which come directly from internal registers.

Optional Feature:
CLIP_COUNT_EN:
- Defined: adds output clip_count [ADDR_W] (width per the package constant).
  - Increments on each WRITE whose wr_data equals the maximum positive value (0x7FFF) or the maximum negative value (0x8000).
  - Cleared at an accepted FRAME_START and by RESET.
  - Holds its value after FRAME_DONE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package fx_pkg: state enum, DATA_W/ADDR_W/FRAME_LEN defaults, and the sample max/min constants.
- One natural sub-module, fx_timeout_counter: clear, enable, and an expired flag at FX_TIMEOUT. The rest is a single FSM.

Test Plan:
- FRAME_LEN=4, RAM={100,-200,0x4000,-0x5000}, overdrive model with GAIN_CFG=0.
  - Output RAM = {200,-400,0x7FFF,0x8000}.
  - FRAME_DONE pulses exactly once; 4 wr_en pulses with addresses 0..3; 20 cycles from FRAME_START to FRAME_DONE (4 samples × 5 cycles).
- BYPASS=1 with the same data: output equals input; fx_start is never asserted; 3 cycles per sample.
- Effect model never asserts DONE at idx 2:
  - ERROR=1 after 15 cycles in FX_WAIT; FRAME_DONE pulses.
  - Only addresses 0 and 1 are written; BUSY=0.
- FRAME_START re-pulsed mid-frame: ignored, with no restart and no change to the latched gain.
- RESET asserted at idx 1: all outputs are 0 on the next cycle and there is no FRAME_DONE. A new FRAME_START then completes the full frame from address 0.
- With CLIP_COUNT_EN defined, the first frame yields clip_count=2. With it undefined, the bench compiles without the port.
